led_status_ctrl: RTL

Sequencer that drives the board's RGB status LED decoder from UART link events. It turns single-cycle error strobes and a level busy flag into timed indications. After reset, a "reset" colour is held for a fixed time. During transfers, a blinking "wait" colour is shown. After errors, an "error" colour is held until a minimum time passes and, optionally, firmware acknowledges. It sits between the UART RX/TX cores and the LED_RGB decoder, whose error/WAIT/reset inputs it drives.

---
 rtl/led_status_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: turns UART error strobes and the busy level into timed
// RGB status indications (reset / wait blink / error hold) for LED_RGB.
module led_status_ctrl #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter bit STICKY       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       err_pulse,
  input  logic       busy,
  input  logic       ack,
  output logic       led_error,
  output logic       led_wait,
  output logic       led_reset,
  output logic [1:0] state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {BOOT = 2'd0, IDLE = 2'd1, BUSY = 2'd2, ERROR = 2'd3} st_t;

  st_t           state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          ack_seen_q, ack_seen_d;
  logic          led_error_d, led_wait_d, led_reset_d;

  logic hold_done, blink_done, entry, restart;

  assign hold_done  = (hold_q == HOLD_MAX);
  assign blink_done = (blink_q == BLINK_MAX);
  // Any state change is an entry; a fresh error while already in ERROR
  // restarts the hold without changing state.
  assign entry      = (state_d != state_q);
  assign restart    = err_pulse && (state_q == ERROR);

  // State, counters and registered LED outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      hold_q     <= '0;
      blink_q    <= '0;
      ack_seen_q <= 1'b0;
      led_reset  <= 1'b1;
      led_error  <= 1'b0;
      led_wait   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
      ack_seen_q <= ack_seen_d;
      led_reset  <= led_reset_d;
      led_error  <= led_error_d;
      led_wait   <= led_wait_d;
    end
  end

  // Next state; err_pulse outranks hold expiry, which outranks busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  if (err_pulse) state_d = ERROR;
             else if (hold_done) state_d = IDLE;
      IDLE:  if (err_pulse) state_d = ERROR;
             else if (busy) state_d = BUSY;
      BUSY:  if (err_pulse) state_d = ERROR;
             else if (!busy) state_d = IDLE;
      ERROR: if (!err_pulse && hold_done && (!STICKY || ack_seen_q))
               state_d = busy ? BUSY : IDLE;
      default: state_d = BOOT;
    endcase
  end

  // Counters and ack latch; hold saturates so a sticky error waits for ack.
  always_comb begin
    hold_d     = '0;
    blink_d    = '0;
    ack_seen_d = 1'b0;
    if (!entry && !restart) begin
      if (state_q == BOOT || state_q == ERROR)
        hold_d = hold_done ? hold_q : hold_q + HW'(1);
      if (state_q == BUSY)
        blink_d = blink_done ? '0 : blink_q + BW'(1);
      if (state_q == ERROR)
        ack_seen_d = ack_seen_q | ack;
    end
  end

  // Next LED values derived from the next state, so at most one is high.
  always_comb begin
    led_reset_d = (state_d == BOOT);
    led_error_d = (state_d == ERROR);
    led_wait_d  = 1'b0;
    if (state_d == BUSY)
      led_wait_d = entry ? 1'b1 : (blink_done ? ~led_wait : led_wait);
  end

  assign state = state_q;

endmodule
